// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/execute pipeline register for a MIPS-style core.
// Decodes the incoming instruction word into ALU controls and operands and
// registers them with stall (hold) and flush (bubble) control.
// Optional feature macro: FORWARD_EN -- when defined, adds the fwd_* write-back
// port and substitutes in-flight write data for matching source registers.
module id_ex_stage #(
    parameter int bit_size = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [31:0]         instr,
    input  logic [bit_size-1:0] rs_data,
    input  logic [bit_size-1:0] rt_data,
`ifdef FORWARD_EN
    input  logic                fwd_wr_en,
    input  logic [4:0]          fwd_wr_addr,
    input  logic [bit_size-1:0] fwd_wr_data,
`endif
    output logic [3:0]          ALUOp,
    output logic [bit_size-1:0] src1,
    output logic [bit_size-1:0] src2,
    output logic [4:0]          shamt,
    output logic [4:0]          rd_addr,
    output logic                reg_write,
    output logic                is_branch,
    output logic                out_valid,
    output logic                illegal
);

    localparam int PW = 4 + 2 * bit_size + 5 + 5 + 4;

    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic [bit_size-1:0] op1;
    logic [bit_size-1:0] op2;
    logic [bit_size-1:0] imm_sext;
    logic [bit_size-1:0] imm_zext;

    logic [3:0]          dec_alu;
    logic                is_r;
    logic                is_i;
    logic                is_b;
    logic                use_sext;

    logic [bit_size-1:0] nxt_src1;
    logic [bit_size-1:0] nxt_src2;
    logic [4:0]          nxt_shamt;
    logic [4:0]          nxt_rd;
    logic                nxt_rw;
    logic                nxt_ill;

    logic [PW-1:0]       stage_d;
    logic [PW-1:0]       stage_q;

    assign opcode   = instr[31:26];
    assign funct    = instr[5:0];
    assign imm_sext = {{(bit_size-16){instr[15]}}, instr[15:0]};
    assign imm_zext = {{(bit_size-16){1'b0}}, instr[15:0]};

`ifdef FORWARD_EN
    // Substitute the in-flight write-back value for a matching non-zero source register
    always_comb begin
        op1 = rs_data;
        op2 = rt_data;
        if (fwd_wr_en && (fwd_wr_addr != 5'd0) && (fwd_wr_addr == instr[25:21])) begin
            op1 = fwd_wr_data;
        end
        if (fwd_wr_en && (fwd_wr_addr != 5'd0) && (fwd_wr_addr == instr[20:16])) begin
            op2 = fwd_wr_data;
        end
    end
`else
    logic unused_rs_field;
    assign unused_rs_field = ^instr[25:21];
    assign op1 = rs_data;
    assign op2 = rt_data;
`endif

    // Classify the instruction and pick the ALU operation code
    always_comb begin
        dec_alu  = 4'b0000;
        is_r     = 1'b0;
        is_i     = 1'b0;
        is_b     = 1'b0;
        use_sext = 1'b0;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: dec_alu = 4'b0001;
                    6'b100010: dec_alu = 4'b0010;
                    6'b100100: dec_alu = 4'b0011;
                    6'b100101: dec_alu = 4'b0100;
                    6'b100110: dec_alu = 4'b0101;
                    6'b100111: dec_alu = 4'b0110;
                    6'b101010: dec_alu = 4'b0111;
                    6'b000000: dec_alu = 4'b1000;
                    6'b000010: dec_alu = 4'b1001;
                    default:   dec_alu = 4'b0000;
                endcase
                is_r = (dec_alu != 4'b0000);
            end
            6'b001000: begin is_i = 1'b1; use_sext = 1'b1; dec_alu = 4'b0001; end
            6'b001010: begin is_i = 1'b1; use_sext = 1'b1; dec_alu = 4'b0111; end
            6'b001100: begin is_i = 1'b1; dec_alu = 4'b0011; end
            6'b001101: begin is_i = 1'b1; dec_alu = 4'b0100; end
            6'b001110: begin is_i = 1'b1; dec_alu = 4'b0101; end
            6'b000100: begin is_b = 1'b1; dec_alu = 4'b1010; end
            6'b000101: begin is_b = 1'b1; dec_alu = 4'b1011; end
            default:   dec_alu = 4'b0000;
        endcase
    end

    // Build operand/destination fields; unrecognised encodings leave everything zero
    always_comb begin
        nxt_src1  = '0;
        nxt_src2  = '0;
        nxt_shamt = 5'd0;
        nxt_rd    = 5'd0;
        if (is_r) begin
            nxt_src1  = op1;
            nxt_src2  = op2;
            nxt_shamt = instr[10:6];
            nxt_rd    = instr[15:11];
        end else if (is_i) begin
            nxt_src1 = op1;
            nxt_src2 = use_sext ? imm_sext : imm_zext;
            nxt_rd   = instr[20:16];
        end else if (is_b) begin
            nxt_src1 = op1;
            nxt_src2 = op2;
        end
        nxt_rw  = (is_r || is_i) && (nxt_rd != 5'd0);
        nxt_ill = !(is_r || is_i || is_b);
        stage_d = {dec_alu, nxt_src1, nxt_src2, nxt_shamt, nxt_rd,
                   nxt_rw, is_b, 1'b1, nxt_ill};
    end

    // Pipeline register: reset clears, flush or an invalid load inserts a bubble, stall holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else if (flush || (!stall && !in_valid)) begin
            stage_q <= '0;
        end else if (!stall) begin
            stage_q <= stage_d;
        end
    end

    assign {ALUOp, src1, src2, shamt, rd_addr, reg_write, is_branch, out_valid, illegal} = stage_q;

endmodule
